// File: rtl/iter_mul.sv
// iter_mul: iterative shift-add multiplier retiring RADIX_BITS multiplier bits per cycle.
// Latency: N+1 edges from accept to out_valid (N = WIDTH/RADIX_BITS); 1 edge for zero operands when skipping.
// Backpressure: one transaction in flight; in_ready low until the product is taken with out_ready.
// Optional feature macro: ITER_MUL_ZERO_SKIP_EN (zero operand bypasses RUN and completes at once).
module iter_mul #(
  parameter int WIDTH      = 32,
  parameter int RADIX_BITS = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic                 in_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_p,
  output logic                 busy
);

  localparam int N  = WIDTH / RADIX_BITS;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  localparam int AW = 2 * WIDTH + RADIX_BITS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                      state;
  logic [CW-1:0]               cnt;
  logic [WIDTH-1:0]            mcand;
  // Upper WIDTH+RADIX_BITS bits hold the running sum; the low WIDTH bits start
  // as the multiplier and fill with finished product bits as it shifts out.
  logic [AW-1:0]               acc;
  logic                        neg;

  logic [WIDTH-1:0]            mag_a;
  logic [WIDTH-1:0]            mag_b;
  logic                        neg_in;
  logic [WIDTH+RADIX_BITS-1:0] pp;
  logic [WIDTH+RADIX_BITS-1:0] hi_sum;
  logic [AW-1:0]               acc_next;
  logic [2*WIDTH-1:0]          prod;

  // Operand magnitudes and result sign, plus one radix step of the shift-add datapath.
  always_comb begin
    mag_a    = (in_signed && in_a[WIDTH-1]) ? (~in_a + WIDTH'(1)) : in_a;
    mag_b    = (in_signed && in_b[WIDTH-1]) ? (~in_b + WIDTH'(1)) : in_b;
    neg_in   = in_signed && (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
    pp       = {{RADIX_BITS{1'b0}}, mcand} * {{WIDTH{1'b0}}, acc[RADIX_BITS-1:0]};
    hi_sum   = acc[AW-1:WIDTH] + pp;
    acc_next = {hi_sum, acc[WIDTH-1:0]} >> RADIX_BITS;
    prod     = acc_next[2*WIDTH-1:0];
  end

  // Control FSM with registered handshake outputs and result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      out_p     <= '0;
      cnt       <= '0;
      mcand     <= '0;
      acc       <= '0;
      neg       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mcand    <= mag_a;
            acc      <= {{(WIDTH + RADIX_BITS){1'b0}}, mag_b};
            neg      <= neg_in;
            cnt      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
`ifdef ITER_MUL_ZERO_SKIP_EN
            if ((in_a == '0) || (in_b == '0)) begin
              state     <= DONE;
              out_valid <= 1'b1;
              out_p     <= '0;
            end else begin
              state <= RUN;
            end
`else
            state <= RUN;
`endif
          end
        end
        RUN: begin
          acc <= acc_next;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state     <= DONE;
            out_valid <= 1'b1;
            out_p     <= neg ? (~prod + (2 * WIDTH)'(1)) : prod;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
